// File: rtl/act_skew_buffer.sv
// rtl/act_skew_buffer.sv - activation staging FIFO with diagonal skew output for the systolic array edge
//
// Stores activation vectors in a circular FIFO and, on start, streams num_vec
// of them into the array with lane i delayed i cycles.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   wr_en, wr_data write one LANES*DATA_W vector (dropped when full)
//   start, num_vec begin streaming num_vec vectors (IDLE only, enough data)
//   full, count    FIFO full flag and occupancy
//   busy, done     busy in STREAM/DRAIN; done pulses once the last element left
//   act_out        registered skewed activations, lane i at [i*DATA_W +: DATA_W]
//   act_valid      per-lane valid; lane data is zero whenever its valid is low
module act_skew_buffer #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [LANES*DATA_W-1:0]      wr_data,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   num_vec,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy,
    output logic                         done,
    output logic [LANES*DATA_W-1:0]      act_out,
    output logic [LANES-1:0]             act_valid
);

    localparam int CW         = $clog2(DEPTH + 1);
    localparam int AW         = $clog2(DEPTH);
    localparam int DCW        = (LANES > 2) ? $clog2(LANES - 1) : 1;
    localparam int DRAIN_LAST = (LANES >= 2) ? LANES - 2 : 0;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    state_t                    state, state_n;
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [CW-1:0]             rem;
    logic [DCW-1:0]            drain_cnt;
    logic [LANES*DATA_W-1:0]   mem [DEPTH];
    logic [LANES*DATA_W-1:0]   rd_vec;
    logic                      wr_acc, pop, start_ok;

    // full is taken from the registered count, so a same-cycle pop never
    // opens room for a write.
    assign full     = (count == CW'(DEPTH));
    assign wr_acc   = wr_en && !full;
    assign start_ok = start && (num_vec != '0) && (count >= num_vec);
    // rem hits zero on the last pop; the following STREAM cycle is spent
    // without a pop so the drain window lines up with the skew depth.
    assign pop      = (state == S_STREAM) && (rem != '0);
    assign rd_vec   = mem[rd_ptr];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start_ok) state_n = S_STREAM;
            S_STREAM: if (rem == '0) state_n = (LANES == 1) ? S_DONE : S_DRAIN;
            S_DRAIN:  if (drain_cnt == DCW'(DRAIN_LAST)) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_STREAM, S_DRAIN: busy = 1'b1;
            S_DONE:            done = 1'b1;
            default:           ;
        endcase
    end

    // Stream bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            rem       <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == S_IDLE && start_ok) rem <= num_vec;
            else if (pop)                    rem <= rem - CW'(1);
            if (state == S_DRAIN) drain_cnt <= drain_cnt + DCW'(1);
            else                  drain_cnt <= '0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({wr_acc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    // Skew line: stage 0 of every lane is the output register fed by the pop;
    // lane i adds i further stages. Zero data enters whenever there is no pop.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0] d_q [0:i];
        logic              v_q [0:i];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    d_q[s] <= '0;
                    v_q[s] <= 1'b0;
                end
            end else begin
                d_q[0] <= pop ? rd_vec[i*DATA_W +: DATA_W] : '0;
                v_q[0] <= pop;
                for (int s = 1; s <= i; s++) begin
                    d_q[s] <= d_q[s-1];
                    v_q[s] <= v_q[s-1];
                end
            end
        end

        assign act_out[i*DATA_W +: DATA_W] = d_q[i];
        assign act_valid[i]                = v_q[i];
    end

endmodule

// File: tb/tb_act_skew_buffer.sv
// tb/tb_act_skew_buffer.sv - scoreboard bench for act_skew_buffer
module tb_act_skew_buffer;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [VW-1:0]     wr_data = '0;
    logic              start = 1'b0;
    logic [CW-1:0]     num_vec = '0;
    logic              full;
    logic [CW-1:0]     count;
    logic              busy;
    logic              done;
    logic [VW-1:0]     act_out;
    logic [LANES-1:0]  act_valid;

    act_skew_buffer #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .num_vec(num_vec), .full(full), .count(count),
        .busy(busy), .done(done), .act_out(act_out), .act_valid(act_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                c;
    } ent_t;

    ent_t          eq [LANES][$];
    logic [VW-1:0] mq [$];
    int            cyc = 0;
    int            exp_done = -1;
    bit            done_seen = 1'b0;
    int            total = 0;
    int            bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops lane expectations as the DUT produces elements.
    always @(negedge clk) begin
        if (!rst && cyc > 1) begin
            for (int i = 0; i < LANES; i++) begin
                if (act_valid[i]) begin
                    if (eq[i].size() == 0) begin
                        chk($sformatf("unexpected_valid_lane%0d", i), 1, 0);
                    end else begin
                        ent_t e;
                        e = eq[i].pop_front();
                        chk($sformatf("data_lane%0d", i), 32'(act_out[i*DATA_W +: DATA_W]), 32'(e.d));
                        chk($sformatf("cycle_lane%0d", i), 32'(cyc), 32'(e.c));
                    end
                end else if (act_out[i*DATA_W +: DATA_W] !== '0) begin
                    chk($sformatf("idle_zero_lane%0d", i), 32'(act_out[i*DATA_W +: DATA_W]), 0);
                end
            end
            if (done) begin
                chk("done_cycle", 32'(cyc), 32'(exp_done));
                chk("busy_at_done", 32'(busy), 0);
                done_seen = 1'b1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input logic [VW-1:0] v);
        wr_en   = 1'b1;
        wr_data = v;
        if (mq.size() < DEPTH) mq.push_back(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_stream(input int nv);
        int t;
        start   = 1'b1;
        num_vec = CW'(nv);
        t = cyc + 1;
        for (int k = 0; k < nv; k++) begin
            logic [VW-1:0] v;
            v = mq.pop_front();
            for (int i = 0; i < LANES; i++) begin
                ent_t e;
                e.d = v[i*DATA_W +: DATA_W];
                e.c = t + 1 + k + i;
                eq[i].push_back(e);
            end
        end
        exp_done = t + nv + LANES;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_done;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (done_seen) break;
        end
        chk("done_seen", 32'(done_seen), 1);
        done_seen = 1'b0;
        exp_done  = -1;
        tick();
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_count", 32'(count), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_act_out", act_out, 0);
        chk("reset_act_valid", 32'(act_valid), 0);

        // Reset mid-idle discards contents
        write_vec(32'h11223344);
        write_vec(32'h55667788);
        chk("count_two", 32'(count), 2);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        mq.delete();
        chk("idle_reset_count", 32'(count), 0);
        chk("idle_reset_valid", 32'(act_valid), 0);

        // Fill to full, overflow dropped, then stream everything
        for (int k = 0; k < DEPTH; k++) write_vec(32'hA0B0C0D0 + 32'(k * 32'h01010101));
        chk("fill_count", 32'(count), DEPTH);
        chk("fill_full", 32'(full), 1);
        write_vec(32'hFFFFFFFF);
        chk("overflow_count", 32'(count), DEPTH);
        start_stream(DEPTH);
        wait_done();
        chk("drain_all_count", 32'(count), 0);

        // Basic two-vector stream
        write_vec(32'h04030201);
        write_vec(32'h08070605);
        start_stream(2);
        wait_done();
        chk("basic_count", 32'(count), 0);

        // Illegal starts are ignored
        write_vec(32'hCAFEF00D);
        start = 1'b1; num_vec = CW'(3);
        tick();
        start = 1'b0;
        chk("illegal_short_busy", 32'(busy), 0);
        start = 1'b1; num_vec = '0;
        tick();
        start = 1'b0;
        chk("illegal_zero_busy", 32'(busy), 0);
        chk("illegal_count", 32'(count), 1);

        // Writes concurrent with streaming
        for (int k = 0; k < DEPTH - 1; k++) write_vec(32'h10203040 + 32'(k));
        chk("refill_full", 32'(full), 1);
        start_stream(DEPTH);
        wr_en = 1'b1; wr_data = 32'hDEADBEEF;          // full at this edge: dropped
        tick();
        chk("full_pop_write_dropped", 32'(count), DEPTH - 1);
        wr_data = 32'h5A6B7C8D;                        // accepted alongside a pop
        mq.push_back(32'h5A6B7C8D);
        tick();
        wr_en = 1'b0;
        chk("write_with_pop_count", 32'(count), DEPTH - 1);
        wait_done();
        chk("leftover_count", 32'(count), 1);
        start_stream(1);
        wait_done();
        chk("leftover_drained", 32'(count), 0);

        // Reset mid-stream
        for (int k = 0; k < 3; k++) write_vec(32'h0F0E0D0C + 32'(k << 4));
        start_stream(3);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < LANES; i++) eq[i].delete();
        mq.delete();
        exp_done = -1;
        tick();
        chk("midrst_valid", 32'(act_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_count", 32'(count), 0);
        rst = 1'b0;
        repeat (10) tick();
        chk("midrst_no_done", 32'(done_seen), 0);

        for (int i = 0; i < LANES; i++)
            chk($sformatf("pending_lane%0d", i), 32'(eq[i].size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/act_skew_buffer.md
# act_skew_buffer

Parametrised activation staging buffer for the systolic array input edge; successor to the fixed single-channel activation timer. It stores incoming activation vectors in a circular SRAM-style FIFO and, on command, streams a chosen number of vectors into the array with the diagonal skew the array needs: lane i is delayed i cycles. Per-lane valid, busy/done status and occupancy reporting are new relative to the previous timer.

## Interface
- LANES, 4, number of array rows / activation lanes (≥1)
- DATA_W, 8, bits per activation element
- DEPTH, 8, FIFO depth in vectors (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write one vector into FIFO
- wr_data  in  LANES*DATA_W  vector; lane i at bits [i*DATA_W +: DATA_W]
- start  in  1  begin streaming num_vec vectors
- num_vec  in  $clog2(DEPTH+1)  vectors to stream, sampled with start
- full  out  1  FIFO holds DEPTH vectors
- count  out  $clog2(DEPTH+1)  current FIFO occupancy
- busy  out  1  high in STREAM or DRAIN
- done  out  1  one-cycle pulse when the last skewed element has left
- act_out  out  LANES*DATA_W  skewed activations to array, registered
- act_valid  out  LANES  per-lane valid; lane data is 0 when its valid is low

## Operation
- FIFO: circular, rd/wr pointers mod DEPTH, separate occupancy counter.
- Write accepted iff wr_en && !full, with full evaluated before any same-cycle pop. A write when full is dropped, even if a pop occurs that cycle.
- A simultaneous accepted write and pop leaves count unchanged.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE→STREAM: start && num_vec!=0 && count≥num_vec. num_vec is latched into remaining counter rem.
- start is otherwise ignored: num_vec==0, insufficient data, or not in IDLE. No error flag.
- STREAM: pop one vector per cycle and decrement rem. When rem reaches 0 after the pop, go to DRAIN.
- Skew line: lane i has a shift register of i stages. Lane 0 has none beyond the output register. A valid bit travels alongside each lane's data.
- DRAIN: no pops. Stay exactly LANES-1 cycles, then go to DONE. With LANES==1, go directly to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in STREAM and DRAIN.
- Writes are accepted in every state, so the host may refill during streaming.
- rst at any time: pointers, count, rem, skew registers, valids and state cleared immediately. Partial stream is abandoned and FIFO contents are discarded.

## Timing
- Reset values: full=0, count=0, busy=0, done=0, act_out=0, act_valid=0, state IDLE.
- start sampled at edge T: state=STREAM, busy=1 after T.
- First pop at edge T+1. Lane 0 of vector 0 is valid after T+1, lane i after T+1+i.
- Vector k, lane i is valid after edge T+1+k+i.
- The last lane of the last vector is valid after edge T+num_vec+LANES-1. done is high after edge T+num_vec+LANES and busy is low at the same point.
- Total start→done = num_vec+LANES edges.
- count and full update on the edge of the write or pop. Back-to-back writes run at 1 vector/cycle.
- A new start is accepted in the cycle after done, when the state is IDLE.

## Test plan
- Reset: assert rst 2 cycles mid-idle → all outputs 0, count=0.
- Fill/full: write 8 vectors (DEPTH=8) → count=8, full=1. 9th write dropped → count stays 8.
- Basic stream: load vectors 0x04030201, 0x08070605, then start with num_vec=2 at edge T → lane0=0x01 valid after T+1, lane3=0x08 valid after T+5, done pulse after T+6, count=0.
- Illegal start: count=1, start with num_vec=3 → ignored, busy stays 0. start with num_vec=0 → ignored.
- Concurrent write during STREAM at count==DEPTH: write dropped. Write at count<DEPTH with pop → count unchanged, new data streamed in a later run.
- Reset mid-STREAM at T+2 → act_valid=0, busy=0, count=0 next cycle, no done pulse.
